// File: rtl/alu_operand_fetch.sv
// LC-3 decode/operand-fetch stage: register file, pending-write scoreboard and a
// registered operand token for the ALU. Define ALU_OF_BYPASS_EN to forward wb_data.
module alu_operand_fetch #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       instr,
    input  logic              wb_en,
    input  logic [2:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [2:0]        out_ctrl,
    output logic [2:0]        out_dr,
    output logic              illegal
);

    localparam int unsigned NREG = 8;

    logic [NREG-1:0][DATA_W-1:0] rf_q, rf_d;
    logic [NREG-1:0]             pend_q, pend_d;
    logic                        out_valid_q, out_valid_d;
    logic [DATA_W-1:0]           out_a_q, out_a_d, out_b_q, out_b_d;
    logic [2:0]                  out_ctrl_q, out_ctrl_d, out_dr_q, out_dr_d;
    logic                        illegal_q, illegal_d;

    logic [2:0]        dr, sr1, sr2, ctrl;
    logic              is_alu, use_sr2, use_imm, b_zero;
    logic [DATA_W-1:0] imm_sext, src1_val, src2_val, opb;
    logic [NREG-1:0]   wb_mask, pend_eff;
    logic              hazard, accept;

    // Instruction decode
    always_comb begin
        dr       = instr[11:9];
        sr1      = instr[8:6];
        sr2      = instr[2:0];
        imm_sext = DATA_W'($signed(instr[4:0]));
        is_alu   = 1'b0;
        use_sr2  = 1'b0;
        use_imm  = 1'b0;
        b_zero   = 1'b0;
        ctrl     = 3'b000;
        case (instr[15:12])
            4'b0001, 4'b0101: begin
                is_alu  = 1'b1;
                ctrl    = (instr[15:12] == 4'b0001) ? 3'b000 : 3'b001;
                use_imm = instr[5];
                use_sr2 = !instr[5];
            end
            4'b1001: begin
                is_alu = 1'b1;
                ctrl   = 3'b010;
                b_zero = 1'b1;
            end
            4'b1101: begin
                if (!instr[5]) begin
                    case (instr[4:3])
                        2'b00: begin is_alu = 1'b1; ctrl = 3'b100; use_sr2 = 1'b1; end
                        2'b01: begin is_alu = 1'b1; ctrl = 3'b110; b_zero = 1'b1; end
                        2'b10: begin is_alu = 1'b1; ctrl = 3'b101; b_zero = 1'b1; end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    // Scoreboard view and operand read; with bypass a same-cycle writeback resolves its hazard
    always_comb begin
        wb_mask  = wb_en ? (NREG'(1) << wb_addr) : '0;
        src1_val = rf_q[sr1];
        src2_val = rf_q[sr2];
`ifdef ALU_OF_BYPASS_EN
        pend_eff = pend_q & ~wb_mask;
        if (wb_en && (wb_addr == sr1)) src1_val = wb_data;
        if (wb_en && (wb_addr == sr2)) src2_val = wb_data;
`else
        pend_eff = pend_q;
`endif
        opb      = use_imm ? imm_sext : (b_zero ? '0 : src2_val);
        hazard   = in_valid && is_alu &&
                   (pend_eff[sr1] || (use_sr2 && pend_eff[sr2]) || pend_eff[dr]);
        in_ready = (!out_valid_q || out_ready) && !hazard;
        accept   = in_valid && in_ready;
    end

    // Next state: register file, scoreboard (set beats clear) and output token
    always_comb begin
        rf_d        = rf_q;
        pend_d      = pend_q & ~wb_mask;
        out_valid_d = out_valid_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_ctrl_d  = out_ctrl_q;
        out_dr_d    = out_dr_q;
        illegal_d   = 1'b0;
        if (wb_en) rf_d[wb_addr] = wb_data;
        if (accept) begin
            if (is_alu) begin
                out_valid_d = 1'b1;
                out_a_d     = src1_val;
                out_b_d     = opb;
                out_ctrl_d  = ctrl;
                out_dr_d    = dr;
                pend_d[dr]  = 1'b1;
            end else begin
                out_valid_d = 1'b0;
                illegal_d   = 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_q        <= '0;
            pend_q      <= '0;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_ctrl_q  <= 3'b000;
            out_dr_q    <= 3'b000;
            illegal_q   <= 1'b0;
        end else begin
            rf_q        <= rf_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_ctrl_q  <= out_ctrl_d;
            out_dr_q    <= out_dr_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_ctrl  = out_ctrl_q;
    assign out_dr    = out_dr_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Bench for alu_operand_fetch: vector table, directed hazard/reset sequences and a
// random run against a cycle-level reference model. Honours ALU_OF_BYPASS_EN.
module tb_alu_operand_fetch;

    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b1, wb_en = 1'b0;
    logic [15:0] instr = '0, wb_data = '0;
    logic [2:0]  wb_addr = '0;
    logic        in_ready, out_valid, illegal;
    logic [15:0] out_a, out_b;
    logic [2:0]  out_ctrl, out_dr;

    int total = 0;
    int bad   = 0;

    alu_operand_fetch #(.DATA_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_a(out_a), .out_b(out_b), .out_ctrl(out_ctrl),
        .out_dr(out_dr), .illegal(illegal)
    );

    always #5 clk = ~clk;

`ifdef ALU_OF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [15:0] ins;
        logic        leg;
        logic [2:0]  ctrl;
        logic [15:0] a;
        logic [15:0] b;
        logic        bc;
        logic [2:0]  dr;
    } vec_t;

    typedef struct {
        logic       legal;
        logic [2:0] ctrl;
        logic [2:0] dr, s1, s2;
        logic       has_s2;
        logic       imm;
        logic       bzero;
    } dec_t;

    logic [15:0] m_regs [8];
    logic        m_pend [8];
    logic        m_ov, m_ill, m_bc;
    logic [15:0] m_a, m_b;
    logic [2:0]  m_ctrl, m_dr;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] rv(input int i);
        return 16'hA000 + 16'(i) * 16'h0123;
    endfunction

    // Reference decode written from the LC-3 opcode table
    function automatic dec_t decode(input logic [15:0] i);
        dec_t d;
        logic [3:0] op;
        op = i[15:12];
        d = '{legal: 1'b0, ctrl: 3'd0, dr: i[11:9], s1: i[8:6], s2: i[2:0],
              has_s2: 1'b0, imm: 1'b0, bzero: 1'b0};
        if (op == 4'h1 || op == 4'h5) begin
            d.legal = 1'b1; d.ctrl = (op == 4'h1) ? 3'd0 : 3'd1;
            d.imm = i[5]; d.has_s2 = !i[5];
        end else if (op == 4'h9) begin
            d.legal = 1'b1; d.ctrl = 3'd2; d.bzero = 1'b1;
        end else if (op == 4'hD && !i[5] && i[4:3] != 2'b11) begin
            d.legal = 1'b1;
            if (i[4:3] == 2'b00) begin d.ctrl = 3'b100; d.has_s2 = 1'b1; end
            else d.ctrl = (i[4:3] == 2'b01) ? 3'b110 : 3'b101;
        end
        return d;
    endfunction

    function automatic logic busy(input logic [2:0] r);
        return m_pend[r] && !(BYP && wb_en && wb_addr == r);
    endfunction

    function automatic logic [15:0] fetch(input logic [2:0] r);
        if (BYP && wb_en && wb_addr == r) return wb_data;
        return m_regs[r];
    endfunction

    function automatic logic [15:0] rand_instr();
        logic [15:0] w;
        int k;
        k = $urandom_range(0, 7);
        w = 16'($urandom);
        case (k)
            0, 7: w[15:12] = 4'h1;
            1:    w[15:12] = 4'h5;
            2:    w[15:12] = 4'h9;
            3, 4: begin w[15:12] = 4'hD; w[5] = ($urandom_range(0, 3) == 0); end
            default: ;
        endcase
        return w;
    endfunction

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        @(negedge clk);
        wb_en = 1'b0;
    endtask

    // Present an instruction until accepted (bounded); returns at the negedge after accept
    task automatic issue(input logic [15:0] ins, output int waited);
        @(negedge clk);
        in_valid = 1'b1; instr = ins; waited = 0;
        #1;
        while (!in_ready && waited < 20) begin
            @(negedge clk); #1; waited++;
        end
        if (!in_ready) begin
            chk("issue_timeout", 16'(waited), 16'd0);
            in_valid = 1'b0;
            waited = -1;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    vec_t tbl [14];

    initial begin
        int w;
        dec_t d;
        logic haz, rdy, acc;

        tbl[0]  = '{16'h147D, 1'b1, 3'b000, 16'hA123, 16'hFFFD, 1'b1, 3'd2};
        tbl[1]  = '{16'h1705, 1'b1, 3'b000, 16'hA48C, 16'hA5AF, 1'b1, 3'd3};
        tbl[2]  = '{16'h5DEF, 1'b1, 3'b001, 16'hA7F5, 16'h000F, 1'b1, 3'd6};
        tbl[3]  = '{16'h5083, 1'b1, 3'b001, 16'hA246, 16'hA369, 1'b1, 3'd0};
        tbl[4]  = '{16'h93BF, 1'b1, 3'b010, 16'hA6D2, 16'h0000, 1'b1, 3'd1};
        tbl[5]  = '{16'hD040, 1'b1, 3'b100, 16'hA123, 16'hA000, 1'b1, 3'd0};
        tbl[6]  = '{16'hD048, 1'b1, 3'b110, 16'hA123, 16'h0000, 1'b0, 3'd0};
        tbl[7]  = '{16'hD050, 1'b1, 3'b101, 16'hA123, 16'h0000, 1'b0, 3'd0};
        tbl[8]  = '{16'hD058, 1'b0, 3'b000, 16'h0000, 16'h0000, 1'b0, 3'd0};
        tbl[9]  = '{16'hD060, 1'b0, 3'b000, 16'h0000, 16'h0000, 1'b0, 3'd0};
        tbl[10] = '{16'h0000, 1'b0, 3'b000, 16'h0000, 16'h0000, 1'b0, 3'd0};
        tbl[11] = '{16'hE000, 1'b0, 3'b000, 16'h0000, 16'h0000, 1'b0, 3'd0};
        tbl[12] = '{16'h1E2F, 1'b1, 3'b000, 16'hA000, 16'h000F, 1'b1, 3'd7};
        tbl[13] = '{16'h1270, 1'b1, 3'b000, 16'hA123, 16'hFFF0, 1'b1, 3'd1};

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ov", 16'(out_valid), 16'd0);
        chk("rst_a", out_a, 16'h0);
        chk("rst_b", out_b, 16'h0);
        chk("rst_ctrl", 16'(out_ctrl), 16'd0);
        chk("rst_dr", 16'(out_dr), 16'd0);
        chk("rst_ill", 16'(illegal), 16'd0);
        chk("rst_rdy", 16'(in_ready), 16'd1);

        for (int i = 0; i < 8; i++) wr(3'(i), rv(i));

        // Vector table; each token's DR is written back with its old value to clear pending
        foreach (tbl[i]) begin
            issue(tbl[i].ins, w);
            chk("tbl_wait", 16'(w), 16'd0);
            chk("tbl_ov", 16'(out_valid), 16'(tbl[i].leg));
            chk("tbl_ill", 16'(illegal), 16'(!tbl[i].leg));
            if (tbl[i].leg) begin
                chk("tbl_a", out_a, tbl[i].a);
                if (tbl[i].bc) chk("tbl_b", out_b, tbl[i].b);
                chk("tbl_ctrl", 16'(out_ctrl), 16'(tbl[i].ctrl));
                chk("tbl_dr", 16'(out_dr), 16'(tbl[i].dr));
                wr(tbl[i].dr, rv(int'(tbl[i].dr)));
            end else begin
                @(negedge clk); #1;
                chk("tbl_ill_end", 16'(illegal), 16'd0);
            end
        end

        // Backpressure: AND R3,R1,R2 held for 4 cycles
        out_ready = 1'b0;
        issue(16'h5642, w);
        in_valid = 1'b1; instr = 16'h1E2F;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("hold_rdy", 16'(in_ready), 16'd0);
            chk("hold_ov", 16'(out_valid), 16'd1);
            chk("hold_a", out_a, 16'hA123);
            chk("hold_b", out_b, 16'hA246);
            chk("hold_ctrl", 16'(out_ctrl), 16'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("hold_release_rdy", 16'(in_ready), 16'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("hold_next_a", out_a, 16'hA000);
        chk("hold_next_dr", 16'(out_dr), 16'd7);
        wr(3'd3, rv(3)); wr(3'd7, rv(7));

        // RAW: ADD R4,R1,#1 then ADD R5,R4,#1, R4 written back three cycles later
        issue(16'h1861, w);
        in_valid = 1'b1; instr = 16'h1B21;
        #1; chk("raw_c1", 16'(in_ready), 16'd0);
        @(negedge clk); #1; chk("raw_c2", 16'(in_ready), 16'd0);
        @(negedge clk);
        wb_en = 1'b1; wb_addr = 3'd4; wb_data = 16'h7777;
        #1; chk("raw_wb_cycle", 16'(in_ready), 16'(BYP));
        if (!BYP) begin
            @(negedge clk);
            wb_en = 1'b0;
            #1; chk("raw_after_wb", 16'(in_ready), 16'd1);
        end
        @(negedge clk);
        wb_en = 1'b0; in_valid = 1'b0;
        chk("raw_ov", 16'(out_valid), 16'd1);
        chk("raw_a", out_a, 16'h7777);
        chk("raw_b", out_b, 16'h0001);
        chk("raw_dr", 16'(out_dr), 16'd5);
        wr(3'd4, rv(4)); wr(3'd5, rv(5));

        // Illegal and no-SR2 instructions with R0 pending
        issue(16'h1061, w);
        issue(16'hD058, w);
        chk("ill1_wait", 16'(w), 16'd0);
        chk("ill1_pulse", 16'(illegal), 16'd1);
        issue(16'h0000, w);
        chk("ill2_wait", 16'(w), 16'd0);
        chk("ill2_pulse", 16'(illegal), 16'd1);
        chk("ill2_ov", 16'(out_valid), 16'd0);
        issue(16'hDC48, w);
        chk("shl_wait", 16'(w), 16'd0);
        chk("shl_ctrl", 16'(out_ctrl), 16'b110);
        issue(16'hDE50, w);
        chk("shr_wait", 16'(w), 16'd0);
        chk("shr_ctrl", 16'(out_ctrl), 16'b101);
        @(negedge clk);
        in_valid = 1'b1; instr = 16'hDA40;
        #1; chk("mul_raw_stall", 16'(in_ready), 16'd0);
        in_valid = 1'b0;
        wr(3'd0, rv(0)); wr(3'd6, rv(6)); wr(3'd7, rv(7));

        // Asynchronous reset with a held token and R4 pending
        out_ready = 1'b0;
        issue(16'h1861, w);
        chk("prerst_ov", 16'(out_valid), 16'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_ov", 16'(out_valid), 16'd0);
        chk("rst_mid_a", out_a, 16'h0);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1; instr = 16'h1B21;
        #1; chk("postrst_rdy", 16'(in_ready), 16'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("postrst_ov", 16'(out_valid), 16'd1);
        chk("postrst_a", out_a, 16'h0000);
        chk("postrst_b", out_b, 16'h0001);

        // Random run against the reference model from a fresh reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin m_regs[i] = '0; m_pend[i] = 1'b0; end
        m_ov = 1'b0; m_ill = 1'b0; m_bc = 1'b0;
        m_a = '0; m_b = '0; m_ctrl = '0; m_dr = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            instr     = rand_instr();
            out_ready = ($urandom_range(0, 3) != 0);
            wb_en     = ($urandom_range(0, 2) == 0);
            wb_addr   = 3'($urandom);
            wb_data   = 16'($urandom);
            #1;
            chk("r_ov", 16'(out_valid), 16'(m_ov));
            chk("r_ill", 16'(illegal), 16'(m_ill));
            if (m_ov) begin
                chk("r_a", out_a, m_a);
                if (m_bc) chk("r_b", out_b, m_b);
                chk("r_ctrl", 16'(out_ctrl), 16'(m_ctrl));
                chk("r_dr", 16'(out_dr), 16'(m_dr));
            end
            d   = decode(instr);
            haz = in_valid && d.legal &&
                  (busy(d.s1) || (d.has_s2 && busy(d.s2)) || busy(d.dr));
            rdy = (!m_ov || out_ready) && !haz;
            chk("r_rdy", 16'(in_ready), 16'(rdy));
            acc   = in_valid && rdy;
            m_ill = acc && !d.legal;
            if (acc && d.legal) begin
                m_ov = 1'b1;
                m_a  = fetch(d.s1);
                m_b  = d.imm ? {{11{instr[4]}}, instr[4:0]} : (d.bzero ? 16'h0 : fetch(d.s2));
                m_bc = !(d.ctrl == 3'b110 || d.ctrl == 3'b101);
                m_ctrl = d.ctrl;
                m_dr   = d.dr;
            end else if (acc || out_ready) begin
                m_ov = 1'b0;
            end
            if (wb_en) begin
                m_regs[wb_addr] = wb_data;
                m_pend[wb_addr] = 1'b0;
            end
            if (acc && d.legal) m_pend[d.dr] = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0; wb_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
